// File: rtl/contador_dec_carga_pkg.sv
// Shared definitions for the display controller slice.
// Holds the load/decrement counter FSM state encoding and the constants
// that bound its parameters.
package contador_dec_carga_pkg;

  // Counter FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } estado_t;

  // Default counter / load-value width
  localparam int unsigned N_DEF     = 8;
  // Prescaler limits (qualified decrement cycles per tick)
  localparam int unsigned PRESC_MIN = 1;
  localparam int unsigned PRESC_MAX = 255;
  // Prescaler counter width, wide enough for PRESC_MAX-1
  localparam int unsigned PRESC_W   = 8;

endpackage

// File: rtl/contador_dec_carga_generador_tic.sv
// generador_tic: prescaler that turns qualified enable cycles into ticks.
// Ports:
//   i_Clk  - clock, rising edge
//   i_Rst  - synchronous active-high reset, clears the count
//   i_Clr  - synchronous clear of the count
//   i_En   - qualified cycle; advances the count, holds it when low
//   o_Tic  - combinational, high when i_En=1 and the count equals PRESC-1
module generador_tic
  import contador_dec_carga_pkg::*;
#(
  parameter int PRESC = 1
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_Clr,
  input  logic i_En,
  output logic o_Tic
);

  localparam logic [PRESC_W-1:0] ULTIMO = PRESC_W'(PRESC - 1);

  logic [PRESC_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_Clr) begin
      cnt_d = '0;
    end else if (i_En) begin
      cnt_d = (cnt_q == ULTIMO) ? '0 : cnt_q + PRESC_W'(1);
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_Tic = i_En && (cnt_q == ULTIMO);

endmodule

// File: rtl/contador_dec_carga.sv
// contador_dec_carga: loadable down-counter with prescaled decrement and
// optional auto-reload on reaching zero.
// Ports:
//   i_Clk     - clock, rising edge
//   i_Rst     - synchronous active-high reset
//   i_Load    - load i_Valor (takes priority over i_Dec)
//   i_Valor   - value captured on load (n bits)
//   i_Dec     - decrement request, level sampled every cycle
//   i_Auto    - reload the last loaded value instead of stopping at zero
//   o_Cta     - registered current count
//   o_Cero    - high when o_Cta == 0
//   o_Fin     - one-cycle registered pulse on the 1 -> 0 (or reload) step
//   o_Ocupado - high while counting (RUN)
module contador_dec_carga
  import contador_dec_carga_pkg::*;
#(
  parameter int n     = 8,
  parameter int PRESC = 1
) (
  input  logic         i_Clk,
  input  logic         i_Rst,
  input  logic         i_Load,
  input  logic [n-1:0] i_Valor,
  input  logic         i_Dec,
  input  logic         i_Auto,
  output logic [n-1:0] o_Cta,
  output logic         o_Cero,
  output logic         o_Fin,
  output logic         o_Ocupado
);

  localparam logic [n-1:0] UNO = n'(1);

  estado_t      estado_q, estado_d;
  logic [n-1:0] cta_q, cta_d;
  logic [n-1:0] recarga_q, recarga_d;
  logic         fin_q, fin_d;
  logic         en_presc;
  logic         tic;

  // A load cycle discards i_Dec, so it must not advance the prescaler.
  assign en_presc = (estado_q == RUN) && i_Dec && !i_Load;

  generador_tic #(
    .PRESC(PRESC)
  ) u_generador_tic (
    .i_Clk (i_Clk),
    .i_Rst (i_Rst),
    .i_Clr (i_Load),
    .i_En  (en_presc),
    .o_Tic (tic)
  );

  always_comb begin
    estado_d  = estado_q;
    cta_d     = cta_q;
    recarga_d = recarga_q;
    fin_d     = 1'b0;
    if (i_Load) begin
      cta_d     = i_Valor;
      recarga_d = i_Valor;
      estado_d  = (i_Valor != '0) ? RUN : DONE;
    end else if (tic) begin
      // tic is only possible in RUN
      if (cta_q > UNO) begin
        cta_d = cta_q - UNO;
      end else if (cta_q == UNO) begin
        fin_d = 1'b1;
        if (i_Auto) begin
          cta_d = recarga_q;
        end else begin
          cta_d    = '0;
          estado_d = DONE;
        end
      end
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      estado_q  <= IDLE;
      cta_q     <= '0;
      recarga_q <= '0;
      fin_q     <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      cta_q     <= cta_d;
      recarga_q <= recarga_d;
      fin_q     <= fin_d;
    end
  end

  assign o_Cta     = cta_q;
  assign o_Cero    = (cta_q == '0);
  assign o_Fin     = fin_q;
  assign o_Ocupado = (estado_q == RUN);

endmodule

// File: tb/tb_contador_dec_carga.sv
// Bench for contador_dec_carga: two instances (PRESC=1 and PRESC=4) share
// the same stimulus; a reference model per instance pushes the expected
// outputs into a queue and a negedge monitor pops and compares them.
module tb_contador_dec_carga;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, load, dec, auto_r;
  logic [7:0] valor;

  logic [7:0] cta1, cta4;
  logic       cero1, fin1, ocup1, cero4, fin4, ocup4;

  contador_dec_carga #(.n(8), .PRESC(1)) dut1 (
    .i_Clk(clk), .i_Rst(rst), .i_Load(load), .i_Valor(valor),
    .i_Dec(dec), .i_Auto(auto_r),
    .o_Cta(cta1), .o_Cero(cero1), .o_Fin(fin1), .o_Ocupado(ocup1)
  );

  contador_dec_carga #(.n(8), .PRESC(4)) dut4 (
    .i_Clk(clk), .i_Rst(rst), .i_Load(load), .i_Valor(valor),
    .i_Dec(dec), .i_Auto(auto_r),
    .o_Cta(cta4), .o_Cero(cero4), .o_Fin(fin4), .o_Ocupado(ocup4)
  );

  typedef struct packed {
    logic [7:0] cta;
    logic       cero;
    logic       fin;
    logic       ocup;
  } exp_t;

  exp_t q1[$];
  exp_t q4[$];

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: modes 0=stopped-after-reset, 1=counting, 2=finished
  int m_cta [2];
  int m_rl  [2];
  int m_pc  [2];
  int m_mode[2];
  int m_fin [2];
  int presc_of[2] = '{1, 4};

  task automatic modelo(input int k, input bit r, input bit l,
                        input int v, input bit d, input bit a);
    exp_t e;
    m_fin[k] = 0;
    if (r) begin
      m_cta[k] = 0; m_rl[k] = 0; m_pc[k] = 0; m_mode[k] = 0;
    end else if (l) begin
      m_cta[k] = v; m_rl[k] = v; m_pc[k] = 0;
      m_mode[k] = (v != 0) ? 1 : 2;
    end else if (m_mode[k] == 1 && d) begin
      m_pc[k] = m_pc[k] + 1;
      if (m_pc[k] == presc_of[k]) begin
        m_pc[k] = 0;
        if (m_cta[k] > 1) begin
          m_cta[k] = m_cta[k] - 1;
        end else if (m_cta[k] == 1) begin
          m_fin[k] = 1;
          if (a) m_cta[k] = m_rl[k];
          else begin
            m_cta[k] = 0; m_mode[k] = 2;
          end
        end
      end
    end
    e.cta  = 8'(m_cta[k]);
    e.cero = (m_cta[k] == 0);
    e.fin  = (m_fin[k] != 0);
    e.ocup = (m_mode[k] == 1);
    if (k == 0) q1.push_back(e);
    else        q4.push_back(e);
  endtask

  task automatic check(input string nm, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, req, $time);
    end
  endtask

  // One clock cycle of stimulus; inputs change 1 time unit after posedge.
  task automatic cyc(input bit r, input bit l, input int v,
                     input bit d, input bit a);
    rst = r; load = l; valor = 8'(v); dec = d; auto_r = a;
    modelo(0, r, l, v, d, a);
    modelo(1, r, l, v, d, a);
    @(posedge clk);
    #1;
  endtask

  exp_t e1, e4;
  always @(negedge clk) begin
    if (q1.size() > 0) begin
      e1 = q1.pop_front();
      check("p1_cta",  int'(cta1),  int'(e1.cta));
      check("p1_cero", int'(cero1), int'(e1.cero));
      check("p1_fin",  int'(fin1),  int'(e1.fin));
      check("p1_ocup", int'(ocup1), int'(e1.ocup));
    end
    if (q4.size() > 0) begin
      e4 = q4.pop_front();
      check("p4_cta",  int'(cta4),  int'(e4.cta));
      check("p4_cero", int'(cero4), int'(e4.cero));
      check("p4_fin",  int'(fin4),  int'(e4.fin));
      check("p4_ocup", int'(ocup4), int'(e4.ocup));
    end
  end

  initial begin
    // Reset for 2 cycles, load 3, count down to DONE, then 5 ignored decs
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 1, 0);
    cyc(0, 1, 3, 0, 0);
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 1, 0);
    // Prescaler gap pattern after loading 2
    cyc(0, 1, 2, 0, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 0);
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 1, 0);
    // Auto-reload with value 2
    cyc(0, 1, 2, 0, 1);
    for (int i = 0; i < 12; i++) cyc(0, 0, 0, 1, 1);
    // Load with simultaneous decrement, then load zero
    cyc(0, 1, 5, 0, 0);
    cyc(0, 1, 9, 1, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 1, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);
    // Reset mid-count at 7
    cyc(0, 1, 7, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0);
    // Full countdown from all-ones
    cyc(0, 1, 255, 0, 0);
    for (int i = 0; i < 262; i++) cyc(0, 0, 0, 1, 0);
    // Randomized traffic
    begin
      bit a = 0;
      for (int i = 0; i < 3000; i++) begin
        bit r, l, d;
        int v;
        r = ($urandom_range(0, 99) < 2);
        l = ($urandom_range(0, 99) < 8);
        d = ($urandom_range(0, 99) < 75);
        if ($urandom_range(0, 49) == 0) a = ~a;
        case ($urandom_range(0, 3))
          0:       v = $urandom_range(0, 5);
          1:       v = 255;
          default: v = $urandom_range(0, 255);
        endcase
        cyc(r, l, v, d, a);
      end
    end
    cyc(0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    #1;
    check("scoreboard_drain", q1.size() + q4.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/contador_dec_carga.md
CONTADOR_DEC_CARGA -- requirements
Module: contador_dec_carga

Interface
REQ-001 Parameter n, default 8, SHALL set the counter and load-value width in bits.
REQ-002 Parameter PRESC, default 1, range 1..255, SHALL set the number of qualified i_Dec cycles per decrement.
REQ-003 i_Clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 i_Rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-005 i_Load  input  1  SHALL request a load of i_Valor.
REQ-006 i_Valor  input  n  SHALL be the value captured on load.
REQ-007 i_Dec  input  1  SHALL be the decrement request, sampled every cycle (level, not edge).
REQ-008 i_Auto  input  1  SHALL select auto-reload on reaching zero.
REQ-009 o_Cta  output  n  SHALL be the registered current count.
REQ-010 o_Cero  output  1  SHALL be high whenever o_Cta == 0.
REQ-011 o_Fin  output  1  SHALL be a one-cycle registered pulse when a decrement takes the count from 1 to 0.
REQ-012 o_Ocupado  output  1  SHALL be high while the FSM is in RUN.

Function
REQ-013 The FSM SHALL have exactly the states IDLE, RUN and DONE.
REQ-014 The block SHALL keep an internal register, reload_val (n bits), holding the last loaded value.
REQ-015 In any state, i_Load=1 SHALL cause all of the following on the next edge:
- o_Cta <= i_Valor and reload_val <= i_Valor;
- prescaler cleared;
- state <= RUN if i_Valor != 0, else DONE;
- o_Fin stays 0.
REQ-016 i_Load SHALL take priority over i_Dec in the same cycle; that cycle's i_Dec SHALL be discarded and not counted by the prescaler.
REQ-017 In RUN with i_Dec=1, the prescaler SHALL increment. Reaching PRESC-1 SHALL produce a tick and return the prescaler to 0. With PRESC=1, every i_Dec cycle SHALL be a tick.
REQ-018 With i_Dec=0, the prescaler SHALL hold its value.
REQ-019 On a tick with o_Cta > 1, o_Cta SHALL decrement by exactly 1 on that edge (latency 1 cycle).
REQ-020 On a tick with o_Cta == 1 and i_Auto=0:
- o_Cta <= 0, state <= DONE;
- o_Fin = 1 for exactly the following cycle.
REQ-021 On a tick with o_Cta == 1 and i_Auto=1:
- o_Cta <= reload_val, state stays RUN;
- o_Fin = 1 for exactly the following cycle.
REQ-022 The count SHALL never wrap: in IDLE and DONE, i_Dec SHALL be ignored and o_Cta SHALL hold.
REQ-023 Decrement arithmetic SHALL be unsigned n-bit. Loading the value 2^n-1 SHALL count down fully.
REQ-024 o_Cero SHALL be derived combinationally from o_Cta. o_Ocupado SHALL be decoded from the state register.

Reset
REQ-025 When i_Rst=1 at a rising edge, the block SHALL set:
- state = IDLE;
- o_Cta = 0, reload_val = 0, prescaler = 0;
- o_Fin = 0, o_Ocupado = 0, o_Cero = 1.
REQ-026 i_Rst SHALL override i_Load and i_Dec in the same cycle, including mid-count in RUN. No o_Fin SHALL be emitted due to reset.

Structure
REQ-027 The state encoding (IDLE, RUN, DONE) SHALL live in a shared package alongside the other display-controller constants.
REQ-028 The prescaler SHALL be a separate sub-module, generador_tic, with these ports and behaviour:
- ports i_Clk, i_Rst, i_Clr, i_En, o_Tic, parameter PRESC;
- o_Tic combinational when the count equals PRESC-1 and i_En=1.
REQ-029 The top level SHALL contain only the FSM, the count register and the reload_val register.

Verification
REQ-030 Reset then load: n=8, PRESC=1, i_Rst for 2 cycles, then i_Load=1 with i_Valor=3 -> next cycle o_Cta=3, o_Ocupado=1, o_Cero=0.
REQ-031 Countdown to DONE: hold i_Dec=1 after loading 3 -> o_Cta goes 2,1,0 on successive cycles; o_Fin=1 only in the cycle o_Cta first reads 0; then DONE, and o_Cta stays 0 for 5 more i_Dec cycles.
REQ-032 Prescaler with gaps: PRESC=4, load 2, i_Dec toggled 1,0,1,1,1 -> o_Cta reaches 1 only after the 4th i_Dec-high cycle; the prescaler holds through the gap.
REQ-033 Auto-reload: i_Auto=1, load 2, i_Dec=1 continuous -> o_Cta sequence 2,1,2,1,2; o_Fin pulses at each 1->2 reload; o_Ocupado stays 1.
REQ-034 Load edge cases: load with i_Load=1 and i_Dec=1 together at o_Cta=5 with i_Valor=9 -> o_Cta=9, no decrement; load 0 -> o_Cta=0, DONE, o_Fin=0.
REQ-035 Reset mid-count: i_Rst=1 at o_Cta=7 in RUN -> next cycle o_Cta=0, IDLE, o_Fin=0, o_Cero=1.
